// File: rtl/memory_data_register_pkg.sv
// Shared CPU datapath constants: word width and the reset word used by the
// MDR, IR, PC and register file.
package memory_data_register_pkg;

   localparam int CPU_DATA_WIDTH = 32;
   localparam logic [CPU_DATA_WIDTH-1:0] CPU_RESET_WORD = 32'h0000_0000;

   typedef logic [CPU_DATA_WIDTH-1:0] cpu_word_t;

endpackage : memory_data_register_pkg

// File: rtl/memory_data_register_checker.sv
// Simulation-only protocol checks for the memory data register: X on the load
// enable, hold stability and one-cycle capture latency.
module memory_data_register_checker #(
   parameter int DATA_WIDTH = 32
) (
   input logic                  clk,
   input logic                  reset,
   input logic                  mdr_write,
   input logic [DATA_WIDTH-1:0] data_in,
   input logic [DATA_WIDTH-1:0] data_out
);

   // An undefined load enable outside reset means the control FSM is broken.
   a_write_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown(mdr_write))
      else $error("mdr_write is X/Z while reset is low");

   a_hold_stable: assert property (@(posedge clk)
      (!reset && !mdr_write) |=> $stable(data_out))
      else $error("data_out changed without a write");

   a_capture: assert property (@(posedge clk)
      (!reset && mdr_write) |=> (data_out == $past(data_in)))
      else $error("data_out does not match the captured word");

endmodule : memory_data_register_checker

// File: rtl/memory_data_register.sv
// Memory data register: holds a word from the memory bus or store path and
// presents it, registered, to the CPU datapath.
module memory_data_register
   import memory_data_register_pkg::*;
#(
   parameter int                    DATA_WIDTH  = CPU_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(CPU_RESET_WORD)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mdr_write,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  mdr_valid
);

   logic [DATA_WIDTH-1:0] data_r;
   logic                  valid_r;

   // Reject degenerate widths at elaboration time.
   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("memory_data_register: DATA_WIDTH must be at least 1");
   end

   // Data word and valid flag; reset takes priority over a write.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r  <= RESET_VALUE;
         valid_r <= 1'b0;
      end else if (mdr_write) begin
         data_r  <= data_in;
         valid_r <= 1'b1;
      end else begin
         data_r  <= data_r;
         valid_r <= valid_r;
      end
   end

   assign data_out  = data_r;
   assign mdr_valid = valid_r;

   memory_data_register_checker #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checker (
      .clk       (clk),
      .reset     (reset),
      .mdr_write (mdr_write),
      .data_in   (data_in),
      .data_out  (data_out)
   );

endmodule : memory_data_register

// File: tb/tb_memory_data_register.sv
// Self-checking bench for memory_data_register: directed cases followed by
// randomized traffic against a behavioural reference model.
module tb_memory_data_register;

   logic        clk;
   logic        reset;
   logic        mdr_write;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        mdr_valid;

   int n_cmp;
   int n_mis;

   // Reference model: the word most recently accepted and whether one exists.
   logic [31:0] model_word;
   logic        model_valid;
   bit          model_known;

   memory_data_register dut (
      .clk       (clk),
      .reset     (reset),
      .mdr_write (mdr_write),
      .data_in   (data_in),
      .data_out  (data_out),
      .mdr_valid (mdr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply inputs, confirm nothing moves before the edge, clock, then compare.
   task automatic step(input string tag, input logic r, input logic w, input logic [31:0] d);
      @(negedge clk);
      reset     = r;
      mdr_write = w;
      data_in   = d;
      #1;
      if (model_known) begin
         check({tag, "_pre_data"}, data_out, model_word);
         check({tag, "_pre_valid"}, {31'b0, mdr_valid}, {31'b0, model_valid});
      end
      @(posedge clk);
      if (r) begin
         model_word  = 32'h0000_0000;
         model_valid = 1'b0;
         model_known = 1'b1;
      end else if (w) begin
         model_word  = d;
         model_valid = 1'b1;
      end
      #1;
      if (model_known) begin
         check({tag, "_data"}, data_out, model_word);
         check({tag, "_valid"}, {31'b0, mdr_valid}, {31'b0, model_valid});
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      model_known = 1'b0;
      model_word  = 32'h0000_0000;
      model_valid = 1'b0;
      reset       = 1'b1;
      mdr_write   = 1'b0;
      data_in     = 32'h0000_0000;

      step("por0", 1'b1, 1'b0, 32'hDEAD_BEEF);
      step("por1", 1'b1, 1'b0, 32'hDEAD_BEEF);
      step("write", 1'b0, 1'b1, 32'hA5A5_A5A5);
      step("hold", 1'b0, 1'b0, 32'h5A5A_5A5A);
      step("overwrite", 1'b0, 1'b1, 32'h1234_5678);
      step("reset", 1'b1, 1'b0, 32'h0BAD_F00D);
      step("rewrite", 1'b0, 1'b1, 32'h8000_0001);
      step("rst_prio", 1'b1, 1'b1, 32'hFFFF_FFFF);
      step("b2b0", 1'b0, 1'b1, 32'hFFFF_FFFF);
      step("b2b1", 1'b0, 1'b1, 32'h0000_0001);
      step("b2b2", 1'b0, 1'b1, 32'h7FFF_FFFE);
      step("rst_mid", 1'b1, 1'b0, 32'h1111_1111);
      step("idle_inv", 1'b0, 1'b0, 32'hCAFE_CAFE);

      for (int i = 0; i < 400; i++) begin
         logic        r;
         logic        w;
         logic [31:0] d;
         r = ($urandom_range(0, 19) == 0);
         w = ($urandom_range(0, 1) == 1);
         d = $urandom;
         step("rand", r, w, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_memory_data_register
